uart_periph: RTL and testbench
==============================

UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning frame data width; legal values 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per TX and RX FIFO; power of 2, 2..256.
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts and checks a parity bit.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 1 selects odd parity and 0 selects even parity.
REQ-005 SHALL have parameter BAUD_DIV_RST, default 434, meaning reset value of the BAUD register, in clk cycles per bit.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-008 SHALL have port ce, input, 1 bit: bus access strobe.
REQ-009 SHALL have port rw, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port address, input, 4 bits: register select.
REQ-011 SHALL have port data_in, input, 32 bits: write data.
REQ-012 SHALL have port data_out, output, 32 bits: read data, combinational from address.
REQ-013 SHALL have port rx, input, 1 bit: serial input, asynchronous to clk.
REQ-014 SHALL have port tx, output, 1 bit: serial output, idle high.
REQ-015 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-016 SHALL decode the registers as follows:
- 0x0 DATA: write pushes data_in[DATA_BITS-1:0] to TX FIFO; read returns the RX FIFO head, zero-extended.
- 0x1 STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_busy, bit5 rx_overrun, bit6 frame_err, bit7 parity_err, bits[23:16] rx_count.
- 0x2 CTRL: bit0 tx_en, bit1 rx_en, bit2 ie_rx_not_empty, bit3 ie_tx_empty, bit4 ie_error.
- 0x3 BAUD: bits[15:0] divisor.
- Other addresses: reads return 0; writes are ignored.
REQ-017 SHALL pop the RX FIFO on the clk edge where ce=1, rw=0 and address=0x0; data_out shows the pre-pop head during that cycle.
REQ-018 SHALL make a read of DATA with the RX FIFO empty return 0 and leave the pointers unchanged.
REQ-019 SHALL drop a DATA write while the TX FIFO is full, with no state change.
REQ-020 SHALL apply push and pop together when both occur in one cycle on the same FIFO; the count is unchanged, and a full FIFO accepts the push.
REQ-021 SHALL wrap FIFO pointers modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
REQ-022 SHALL clear the sticky error bits STATUS[7:5] by writing 1 to the corresponding bit of STATUS; all other STATUS bits are read-only.
REQ-023 SHALL treat a BAUD divisor below 4 as 4; a new divisor takes effect at the next bit-period start of each FSM.
REQ-024 SHALL sequence the TX FSM IDLE -> START -> DATA -> PARITY (only when PARITY_EN=1) -> STOP -> IDLE:
- Each state lasts divisor cycles.
- Data is sent LSB first.
- STOP drives 1.
REQ-025 SHALL leave TX IDLE when tx_en=1 and the TX FIFO is non-empty: pop the head and drive tx=0 on the next edge.
REQ-026 SHALL chain frames with no idle gap: STOP goes directly to START when the FIFO is non-empty and tx_en=1.
REQ-027 SHALL let a frame in progress complete when tx_en clears; no new frame starts.
REQ-028 SHALL assert tx_busy whenever the TX FSM is not in IDLE.
REQ-029 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-030 SHALL sequence the RX FSM IDLE -> START -> DATA -> PARITY (only when PARITY_EN=1) -> STOP -> IDLE:
- rx_en=1 and a synchronized falling edge enter START.
- At divisor/2 cycles, a sample of 1 returns to IDLE (glitch rejection); otherwise sampling continues every divisor cycles.
REQ-031 SHALL, at the STOP sample:
- If the sample is 0: set frame_err and discard the byte.
- If parity mismatches: set parity_err and discard the byte.
- If the RX FIFO is full: set rx_overrun and discard the byte.
- Otherwise push the byte.
REQ-032 SHALL drive irq = (ie_rx_not_empty & ~rx_empty) | (ie_tx_empty & tx_empty & ~tx_busy) | (ie_error & |STATUS[7:5]), registered, so irq lags its cause by one cycle.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force:
- tx=1, irq=0, both FSMs to IDLE, FIFOs empty.
- Sticky bits 0, CTRL=0x03, BAUD=BAUD_DIV_RST.
- Synchronizer flops to 1.
REQ-034 SHALL make reset mid-frame abort the frame immediately; tx returns high with no partial stop bit.
REQ-035 SHALL make data_out reflect the reset register state while rst_n=0.

Verification
REQ-036 SHALL cover TX of one byte: BAUD=4, write DATA=0xA5 -> tx low 1 cycle later; bits 1,0,1,0,0,1,0,1, 4 cycles each; stop high; tx_busy low at cycle 41.
REQ-037 SHALL cover RX loopback: tx tied to rx, write 0x3C and 0xC3 -> rx_count=2; reads return 0x3C then 0xC3; rx_empty=1.
REQ-038 SHALL cover RX overrun: FIFO_DEPTH=4, inject 5 frames without reads -> rx_full=1, rx_overrun=1, first 4 bytes intact; writing STATUS=0x20 clears rx_overrun.
REQ-039 SHALL cover framing and parity errors: PARITY_EN=1 with a stop bit of 0 -> frame_err=1 and no push; a wrong parity bit -> parity_err=1; with ie_error=1, irq=1 one cycle later.
REQ-040 SHALL cover glitch and full TX FIFO: an rx low pulse of 1 cycle -> no frame; 17 writes with FIFO_DEPTH=16 and tx_en=0 -> 17th dropped, count=16.
REQ-041 SHALL cover reset mid-frame: rst_n low during DATA bit 3 -> tx=1 immediately, tx_empty=1, CTRL=0x03 after release.

Source files
------------

// File: rtl/uart_periph.sv
// UART peripheral: register-mapped TX/RX FIFOs, programmable baud divisor,
// optional parity, sticky error flags and a registered level interrupt.

module uart_periph_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i)  rp_q <= rp_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (!push_i && pop_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rdata_o = mem_q[rp_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

module uart_periph #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned BAUD_DIV_RST = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        rw,
  input  logic [3:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic        PAR_EN  = (PARITY_EN != 0);
  localparam logic        PAR_ODD = (PARITY_ODD != 0);
  localparam logic [2:0]  LAST    = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic [4:0]  ctrl_q;
  logic [15:0] baud_q, div;
  logic [2:0]  err_q, err_d;            // {parity, frame, overrun}
  logic        irq_q;
  logic        wr_en, rd_en;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic [CW-1:0]        tx_cnt;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head;
  logic [CW-1:0]        rx_cnt;

  state_e               tx_st_q, rx_st_q;
  logic [15:0]          tx_tmr_q, rx_tmr_q;
  logic [DATA_BITS-1:0] tx_sh_q, rx_sh_q;
  logic [2:0]           tx_bit_q, rx_bit_q;
  logic                 tx_par_q, tx_q, rx_pbit_q;
  logic [1:0]           sync_q;
  logic                 rx_s, rx_prev_q;
  logic                 tx_tick, rx_tick, tx_busy, stop_smp, par_bad, unused_hi;

  assign wr_en     = ce & rw;
  assign rd_en     = ce & ~rw;
  assign div       = (baud_q < 16'd4) ? 16'd4 : baud_q;
  assign unused_hi = ^data_in[31:16];

  assign tx_tick  = (tx_tmr_q == '0);
  assign tx_busy  = (tx_st_q != S_IDLE);
  assign tx_pop   = ctrl_q[0] && !tx_empty &&
                    (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_tick));
  assign tx_push  = wr_en && address == 4'h0 && (!tx_full || tx_pop);
  assign rx_pop   = rd_en && address == 4'h0 && !rx_empty;

  assign rx_s     = sync_q[1];
  assign rx_tick  = (rx_tmr_q == '0);
  assign stop_smp = (rx_st_q == S_STOP) && rx_tick;
  assign par_bad  = PAR_EN && (rx_pbit_q != (^rx_sh_q ^ PAR_ODD));
  assign rx_push  = stop_smp && rx_s && !par_bad && (!rx_full || rx_pop);

  uart_periph_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_pop), .wdata_i(data_in[DATA_BITS-1:0]),
    .rdata_o(tx_head), .count_o(tx_cnt), .full_o(tx_full), .empty_o(tx_empty));

  uart_periph_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .rst_n(rst_n), .push_i(rx_push), .pop_i(rx_pop), .wdata_i(rx_sh_q),
    .rdata_o(rx_head), .count_o(rx_cnt), .full_o(rx_full), .empty_o(rx_empty));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q <= S_IDLE; tx_tmr_q <= '0; tx_sh_q <= '0;
      tx_bit_q <= '0;    tx_par_q <= 1'b0; tx_q <= 1'b1;
    end else begin
      if (tx_busy && !tx_tick) tx_tmr_q <= tx_tmr_q - 16'd1;
      case (tx_st_q)
        S_IDLE, S_STOP: begin
          if (tx_st_q == S_IDLE || tx_tick) begin
            if (tx_pop) begin
              tx_st_q  <= S_START;
              tx_q     <= 1'b0;
              tx_sh_q  <= tx_head;
              tx_par_q <= ^tx_head ^ PAR_ODD;
              tx_tmr_q <= div - 16'd1;
            end else begin
              tx_st_q <= S_IDLE;
            end
          end
        end
        S_START: if (tx_tick) begin
          tx_st_q  <= S_DATA;
          tx_q     <= tx_sh_q[0];
          tx_sh_q  <= tx_sh_q >> 1;
          tx_bit_q <= '0;
          tx_tmr_q <= div - 16'd1;
        end
        S_DATA: if (tx_tick) begin
          tx_tmr_q <= div - 16'd1;
          if (tx_bit_q == LAST) begin
            tx_st_q <= PAR_EN ? S_PARITY : S_STOP;
            tx_q    <= PAR_EN ? tx_par_q : 1'b1;
          end else begin
            tx_bit_q <= tx_bit_q + 3'd1;
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end
        end
        S_PARITY: if (tx_tick) begin
          tx_st_q  <= S_STOP;
          tx_q     <= 1'b1;
          tx_tmr_q <= div - 16'd1;
        end
        default: tx_st_q <= S_IDLE;
      endcase
    end
  end

  // The first wait is half a bit so later samples land mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11; rx_prev_q <= 1'b1; rx_st_q <= S_IDLE;
      rx_tmr_q <= '0;  rx_sh_q <= '0;     rx_bit_q <= '0; rx_pbit_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
      if (rx_st_q != S_IDLE && !rx_tick) rx_tmr_q <= rx_tmr_q - 16'd1;
      case (rx_st_q)
        S_IDLE: if (ctrl_q[1] && rx_prev_q && !rx_s) begin
          rx_st_q  <= S_START;
          rx_tmr_q <= (div >> 1) - 16'd1;
        end
        S_START: if (rx_tick) begin
          rx_st_q  <= rx_s ? S_IDLE : S_DATA;
          rx_tmr_q <= div - 16'd1;
          rx_bit_q <= '0;
        end
        S_DATA: if (rx_tick) begin
          rx_sh_q  <= {rx_s, rx_sh_q[DATA_BITS-1:1]};
          rx_tmr_q <= div - 16'd1;
          if (rx_bit_q == LAST) rx_st_q <= PAR_EN ? S_PARITY : S_STOP;
          else                  rx_bit_q <= rx_bit_q + 3'd1;
        end
        S_PARITY: if (rx_tick) begin
          rx_pbit_q <= rx_s;
          rx_st_q   <= S_STOP;
          rx_tmr_q  <= div - 16'd1;
        end
        S_STOP: if (rx_tick) rx_st_q <= S_IDLE;
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (wr_en && address == 4'h1) err_d = err_d & ~data_in[7:5];
    if (stop_smp) begin
      if (!rx_s)                  err_d[1] = 1'b1;
      else if (par_bad)           err_d[2] = 1'b1;
      else if (rx_full && !rx_pop) err_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= 5'h03;
      baud_q <= 16'(BAUD_DIV_RST);
      err_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (wr_en && address == 4'h2) ctrl_q <= data_in[4:0];
      if (wr_en && address == 4'h3) baud_q <= data_in[15:0];
      irq_q <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty & ~tx_busy) |
               (ctrl_q[4] & |err_q);
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      4'h0: data_out = rx_empty ? '0 : 32'(rx_head);
      4'h1: data_out = {8'h00, 8'(rx_cnt), 8'h00, err_q, tx_busy,
                        rx_empty, rx_full, tx_empty, tx_full};
      4'h2: data_out = {27'd0, ctrl_q};
      4'h3: data_out = {16'd0, baud_q};
      default: data_out = '0;
    endcase
  end

  assign tx  = tx_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_uart_periph.sv
// Directed bench: dut0 uses default parameters (plus loopback), dut1 is a
// 4-deep parity-enabled instance driven with hand-built serial frames.

module tb_uart_periph;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce   [2];
  logic        rw   [2];
  logic [3:0]  addr [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        txo  [2];
  logic        irqo [2];
  logic        rx0, rx_drv0, rx1, loop0;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] v;
  logic [7:0]  b;
  logic        found;

  always #5 clk = ~clk;
  assign rx0 = loop0 ? txo[0] : rx_drv0;

  uart_periph #(.DATA_BITS(8), .FIFO_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0),
                .BAUD_DIV_RST(434)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce[0]), .rw(rw[0]), .address(addr[0]),
    .data_in(din[0]), .data_out(dout[0]), .rx(rx0), .tx(txo[0]), .irq(irqo[0]));

  uart_periph #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0),
                .BAUD_DIV_RST(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce[1]), .rw(rw[1]), .address(addr[1]),
    .data_in(din[1]), .data_out(dout[1]), .rx(rx1), .tx(txo[1]), .irq(irqo[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int s, input logic [3:0] a, input logic [31:0] d);
    ce[s] = 1'b1; rw[s] = 1'b1; addr[s] = a; din[s] = d;
    tick();
    ce[s] = 1'b0; rw[s] = 1'b0;
  endtask

  task automatic rdreg(input int s, input logic [3:0] a, output logic [31:0] o);
    ce[s] = 1'b0; rw[s] = 1'b0; addr[s] = a;
    #1 o = dout[s];
  endtask

  task automatic pop(input int s, output logic [31:0] o);
    ce[s] = 1'b1; rw[s] = 1'b0; addr[s] = 4'h0;
    #1 o = dout[s];
    tick();
    ce[s] = 1'b0;
  endtask

  task automatic send_bits1(input logic [7:0] d, input logic pflip);
    rx1 = 1'b0; repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      rx1 = d[i]; repeat (4) tick();
    end
    rx1 = (^d) ^ pflip; repeat (4) tick();
  endtask

  task automatic send_frame1(input logic [7:0] d, input logic pflip, input logic stopv);
    send_bits1(d, pflip);
    rx1 = stopv; repeat (4) tick();
    rx1 = 1'b1;  repeat (8) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      ce[s] = 1'b0; rw[s] = 1'b0; addr[s] = '0; din[s] = '0;
    end
    rx_drv0 = 1'b1; rx1 = 1'b1; loop0 = 1'b0; rst_n = 1'b0;
    #12;
    chk("rst_tx0", txo[0], 1);
    chk("rst_tx1", txo[1], 1);
    chk("rst_irq", irqo[0], 0);
    rdreg(0, 4'h1, v); chk("rst_status", v, 32'h0000_000A);
    rdreg(0, 4'h2, v); chk("rst_ctrl", v, 32'h3);
    rdreg(0, 4'h3, v); chk("rst_baud", v, 32'd434);
    #8 rst_n = 1'b1;
    tick();

    wr(0, 4'h3, 32'd4);
    rdreg(0, 4'h3, v); chk("baud_wr", v, 32'd4);

    // single byte 0xA5 on tx, 4 cycles per bit
    b = 8'hA5;
    wr(0, 4'h0, 32'hA5);
    chk("tx_idle_e0", txo[0], 1);
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k == 1) chk("tx_start", txo[0], 0);
      if (k == 4) chk("tx_start_end", txo[0], 0);
      if (k >= 5 && k <= 36 && (k % 4) == 1) chk($sformatf("tx_bit%0d", (k - 5) / 4), txo[0], b[(k - 5) / 4]);
      if (k == 37) chk("tx_stop", txo[0], 1);
      if (k == 40) begin rdreg(0, 4'h1, v); chk("tx_busy40", v[4], 1); end
      if (k == 41) begin rdreg(0, 4'h1, v); chk("tx_busy41", v[4], 0); end
    end

    // loopback of two chained frames
    loop0 = 1'b1;
    wr(0, 4'h0, 32'h3C);
    wr(0, 4'h0, 32'hC3);
    repeat (120) tick();
    rdreg(0, 4'h1, v); chk("lb_count", v[23:16], 2);
    pop(0, v); chk("lb_rd0", v, 32'h3C);
    pop(0, v); chk("lb_rd1", v, 32'hC3);
    rdreg(0, 4'h1, v); chk("lb_empty", v[3], 1);
    pop(0, v); chk("rd_empty_zero", v, 0);
    rdreg(0, 4'h1, v); chk("rd_empty_cnt", v[23:16], 0);

    // one-cycle low glitch must not start a frame
    loop0 = 1'b0;
    rx_drv0 = 1'b0; tick(); rx_drv0 = 1'b1;
    repeat (40) tick();
    rdreg(0, 4'h1, v); chk("glitch_cnt", v[23:16], 0);
    chk("glitch_err", v[7:5], 0);

    // 17 writes with tx disabled: last one dropped
    wr(0, 4'h2, 32'h2);
    for (int i = 0; i < 17; i++) wr(0, 4'h0, 32'h10 + i);
    rdreg(0, 4'h1, v); chk("txf_full", v[1:0], 2'b01);
    loop0 = 1'b1;
    wr(0, 4'h2, 32'h3);
    repeat (700) tick();
    rdreg(0, 4'h1, v);
    chk("txf_rxcnt", v[23:16], 16);
    chk("txf_rxfull", v[2], 1);
    chk("txf_noovr", v[5], 0);
    chk("txf_txempty", v[1], 1);
    for (int i = 0; i < 16; i++) begin
      pop(0, v); chk($sformatf("txf_rd%0d", i), v, 32'h10 + i);
    end
    rdreg(0, 4'h1, v); chk("txf_drained", v[3], 1);
    loop0 = 1'b0;

    // dut1: overrun with 5 frames into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      b = 8'(8'h11 * (i + 1));
      send_frame1(b, 1'b0, 1'b1);
    end
    rdreg(1, 4'h1, v);
    chk("ovr_full", v[2], 1);
    chk("ovr_flag", v[5], 1);
    chk("ovr_cnt", v[23:16], 4);
    for (int i = 0; i < 4; i++) begin
      pop(1, v); chk($sformatf("ovr_rd%0d", i), v, 32'(8'(8'h11 * (i + 1))));
    end
    wr(1, 4'h1, 32'h20);
    rdreg(1, 4'h1, v); chk("ovr_clear", v[7:5], 0);

    // framing error: stop bit low
    send_frame1(8'h5A, 1'b0, 1'b0);
    rdreg(1, 4'h1, v);
    chk("frm_err", v[7:5], 3'b010);
    chk("frm_nopush", v[3], 1);

    // parity error with error interrupt enabled
    wr(1, 4'h1, 32'hE0);
    wr(1, 4'h2, 32'h13);
    tick();
    chk("par_irq_pre", irqo[1], 0);
    send_bits1(8'h5A, 1'b1);
    rx1 = 1'b1; ce[1] = 1'b0; addr[1] = 4'h1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (dout[1][7]) begin
        found = 1'b1;
        chk("par_irq_lag", irqo[1], 0);
        tick();
        chk("par_irq", irqo[1], 1);
      end
    end
    chk("par_seen", found, 1);
    rdreg(1, 4'h1, v);
    chk("par_nofrm", v[6], 0);
    chk("par_nopush", v[3], 1);
    repeat (8) tick();

    // dut0: registered irq, then reset during data bit 3
    wr(0, 4'h2, 32'h0B);
    chk("irq_lag", irqo[0], 0);
    tick();
    chk("irq_txempty", irqo[0], 1);
    wr(0, 4'h0, 32'h00);
    repeat (18) tick();
    chk("mid_tx_low", txo[0], 0);
    rdreg(0, 4'h1, v); chk("mid_busy", v[4], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", txo[0], 1);
    chk("mid_rst_irq", irqo[0], 0);
    rdreg(0, 4'h1, v);
    chk("mid_rst_txempty", v[1], 1);
    chk("mid_rst_busy", v[4], 0);
    #3 rst_n = 1'b1;
    tick();
    rdreg(0, 4'h2, v); chk("mid_ctrl", v, 32'h3);
    rdreg(0, 4'h3, v); chk("mid_baud", v, 32'd434);
    chk("mid_tx_idle", txo[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
